// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: retrigger on note match, else lowest free voice, else steal oldest.
// Outputs are registered one cycle after the event; no backpressure, one event accepted per cycle.
module voice_allocator #(
    parameter int NVOICE = 4
) (
    input  logic                  clk_50m,
    input  logic                  rst_n,
    input  logic                  ev_valid,
    input  logic                  ev_on,
    input  logic [6:0]            ev_note,
    input  logic [7:0]            ev_vel,
    input  logic                  all_off,
    output logic [NVOICE-1:0]     voice_gate,
    output logic [NVOICE-1:0]     voice_trig,
    output logic [7*NVOICE-1:0]   voice_note,
    output logic [8*NVOICE-1:0]   voice_vel
);

    localparam int AW = $clog2(NVOICE);

    logic [AW-1:0] age [NVOICE];

    logic          match_hit;
    logic [AW-1:0] match_idx;
    logic          free_hit;
    logic [AW-1:0] free_idx;
    logic [AW-1:0] old_idx;
    logic [AW-1:0] chosen_idx;
    logic [AW-1:0] chosen_age;
    logic          note_on;
    logic          note_off;

    assign note_on  = ev_valid && ev_on && !all_off;
    assign note_off = ev_valid && !ev_on && !all_off;

    // Scan from the top so the lowest-index candidate is the one left standing.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        old_idx   = '0;
        for (int i = NVOICE - 1; i >= 0; i--) begin
            if (voice_gate[i] && (voice_note[7*i +: 7] == ev_note)) begin
                match_hit = 1'b1;
                match_idx = AW'(i);
            end
            if (!voice_gate[i]) begin
                free_hit = 1'b1;
                free_idx = AW'(i);
            end
            if (age[i] == AW'(NVOICE - 1)) begin
                old_idx = AW'(i);
            end
        end
        if (match_hit) begin
            chosen_idx = match_idx;
        end else if (free_hit) begin
            chosen_idx = free_idx;
        end else begin
            chosen_idx = old_idx;
        end
        chosen_age = '0;
        for (int i = 0; i < NVOICE; i++) begin
            if (AW'(i) == chosen_idx) begin
                chosen_age = age[i];
            end
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            voice_gate <= '0;
            voice_trig <= '0;
            voice_note <= '0;
            voice_vel  <= '0;
            for (int i = 0; i < NVOICE; i++) begin
                age[i] <= AW'(i);
            end
        end else begin
            voice_trig <= '0;
            if (all_off) begin
                voice_gate <= '0;
            end else if (note_on) begin
                // Chosen voice becomes newest; only voices younger than it age by one.
                for (int i = 0; i < NVOICE; i++) begin
                    if (AW'(i) == chosen_idx) begin
                        voice_gate[i]        <= 1'b1;
                        voice_trig[i]        <= 1'b1;
                        voice_note[7*i +: 7] <= ev_note;
                        voice_vel[8*i +: 8]  <= ev_vel;
                        age[i]               <= '0;
                    end else if (age[i] < chosen_age) begin
                        age[i] <= age[i] + AW'(1);
                    end
                end
            end else if (note_off && match_hit) begin
                for (int i = 0; i < NVOICE; i++) begin
                    if (AW'(i) == match_idx) begin
                        voice_gate[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Randomized bench for voice_allocator with a queue-based age model and directed scenario checks.
module tb_voice_allocator;

    localparam int NV = 4;

    logic              clk_50m = 1'b0;
    logic              rst_n   = 1'b0;
    logic              ev_valid = 1'b0;
    logic              ev_on    = 1'b0;
    logic [6:0]        ev_note  = '0;
    logic [7:0]        ev_vel   = '0;
    logic              all_off  = 1'b0;
    logic [NV-1:0]     voice_gate;
    logic [NV-1:0]     voice_trig;
    logic [7*NV-1:0]   voice_note;
    logic [8*NV-1:0]   voice_vel;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Model: voices ordered newest-first in a queue; age is the queue position.
    bit         m_gate [NV];
    bit         m_trig [NV];
    logic [6:0] m_note [NV];
    logic [7:0] m_vel  [NV];
    int         order [$];

    voice_allocator #(.NVOICE(NV)) dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .ev_valid   (ev_valid),
        .ev_on      (ev_on),
        .ev_note    (ev_note),
        .ev_vel     (ev_vel),
        .all_off    (all_off),
        .voice_gate (voice_gate),
        .voice_trig (voice_trig),
        .voice_note (voice_note),
        .voice_vel  (voice_vel)
    );

    always #10 clk_50m = ~clk_50m;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] note_of(input int i);
        return voice_note[7*i +: 7];
    endfunction

    function automatic logic [7:0] vel_of(input int i);
        return voice_vel[8*i +: 8];
    endfunction

    always @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            order.delete();
            for (int i = 0; i < NV; i++) begin
                m_gate[i] = 1'b0;
                m_trig[i] = 1'b0;
                m_note[i] = '0;
                m_vel[i]  = '0;
                order.push_back(i);
            end
        end else begin
            int idx;
            for (int i = 0; i < NV; i++) m_trig[i] = 1'b0;
            if (all_off) begin
                for (int i = 0; i < NV; i++) m_gate[i] = 1'b0;
            end else if (ev_valid) begin
                idx = -1;
                for (int i = 0; i < NV; i++)
                    if (m_gate[i] && m_note[i] == ev_note) idx = i;
                if (ev_on) begin
                    if (idx < 0)
                        for (int i = NV - 1; i >= 0; i--)
                            if (!m_gate[i]) idx = i;
                    if (idx < 0) idx = order[NV-1];
                    m_gate[idx] = 1'b1;
                    m_trig[idx] = 1'b1;
                    m_note[idx] = ev_note;
                    m_vel[idx]  = ev_vel;
                    for (int p = 0; p < order.size(); p++) begin
                        if (order[p] == idx) begin
                            order.delete(p);
                            break;
                        end
                    end
                    order.push_front(idx);
                end else if (idx >= 0) begin
                    m_gate[idx] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk_50m) begin
        if (cmp_en) begin
            bit dup;
            for (int i = 0; i < NV; i++) begin
                chk($sformatf("gate[%0d]", i), voice_gate[i], m_gate[i]);
                chk($sformatf("trig[%0d]", i), voice_trig[i], m_trig[i]);
                chk($sformatf("note[%0d]", i), note_of(i), m_note[i]);
                chk($sformatf("vel[%0d]", i),  vel_of(i),  m_vel[i]);
            end
            chk("trig_onehot0", ($countones(voice_trig) <= 1), 1);
            dup = 1'b0;
            for (int i = 0; i < NV; i++)
                for (int j = i + 1; j < NV; j++)
                    if (voice_gate[i] && voice_gate[j] && note_of(i) == note_of(j)) dup = 1'b1;
            chk("one_gate_per_note", dup, 0);
        end
    end

    task automatic do_reset();
        ev_valid = 1'b0;
        all_off  = 1'b0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk_50m);
        @(negedge clk_50m);
        rst_n = 1'b1;
    endtask

    task automatic send(input bit v, input bit on, input int note, input int vel, input bit ao);
        @(negedge clk_50m);
        ev_valid = v;
        ev_on    = on;
        ev_note  = 7'(note);
        ev_vel   = 8'(vel);
        all_off  = ao;
        @(posedge clk_50m);
        #1;
        ev_valid = 1'b0;
        all_off  = 1'b0;
    endtask

    initial begin
        bit has48;
        @(posedge clk_50m);
        #1 cmp_en = 1'b1;
        do_reset();
        chk("rst_gate", voice_gate, 0);
        chk("rst_trig", voice_trig, 0);
        chk("rst_note", voice_note, 0);
        chk("rst_vel",  voice_vel,  0);

        send(1, 1, 60, 100, 0);
        chk("on60_gate", voice_gate, 4'b0001);
        chk("on60_trig", voice_trig, 4'b0001);
        chk("on60_note", note_of(0), 60);
        chk("on60_vel",  vel_of(0),  100);
        send(1, 1, 60, 50, 0);
        chk("retrig_gate", voice_gate, 4'b0001);
        chk("retrig_trig", voice_trig, 4'b0001);
        chk("retrig_vel",  vel_of(0),  50);
        @(posedge clk_50m);
        #1 chk("trig_idle", voice_trig, 0);

        do_reset();
        send(1, 1, 60, 10, 0);
        send(1, 1, 62, 20, 0);
        send(1, 1, 64, 30, 0);
        send(1, 1, 65, 40, 0);
        send(1, 1, 67, 50, 0);
        chk("steal_trig", voice_trig, 4'b0001);
        chk("steal_gate", voice_gate, 4'b1111);
        chk("steal_note", note_of(0), 67);
        send(1, 1, 48, 90, 1);
        has48 = 1'b0;
        for (int i = 0; i < NV; i++) if (note_of(i) == 48) has48 = 1'b1;
        chk("alloff_gate", voice_gate, 4'b0000);
        chk("alloff_trig", voice_trig, 4'b0000);
        chk("alloff_no48", has48, 0);

        do_reset();
        send(1, 1, 60, 100, 0);
        send(1, 1, 62, 100, 0);
        send(1, 0, 60, 0, 0);
        chk("off60_gate", voice_gate, 4'b0010);
        send(1, 1, 70, 77, 0);
        chk("on70_trig", voice_trig, 4'b0001);
        chk("on70_gate", voice_gate, 4'b0011);
        chk("on70_note", note_of(0), 70);
        send(1, 0, 72, 0, 0);
        chk("off72_gate", voice_gate, 4'b0011);
        chk("off72_trig", voice_trig, 4'b0000);
        chk("off72_note1", note_of(1), 62);
        send(1, 1, 80, 0, 0);
        chk("vel0_trig", voice_trig, 4'b0100);
        chk("vel0_vel",  vel_of(2),  0);

        for (int k = 0; k < 3000; k++) begin
            @(negedge clk_50m);
            if ($urandom_range(0, 399) == 0) begin
                ev_valid = 1'b0;
                all_off  = 1'b0;
                #3 rst_n = 1'b0;
                #1;
                chk("midrst_gate", voice_gate, 0);
                chk("midrst_trig", voice_trig, 0);
                @(negedge clk_50m);
                rst_n    = 1'b1;
                ev_valid = 1'b1;
                ev_on    = 1'b1;
                ev_note  = 7'(60 + $urandom_range(0, 7));
                ev_vel   = 8'($urandom);
                @(posedge clk_50m);
                #1 chk("post_rst_trig", voice_trig, 4'b0001);
            end else begin
                ev_valid = ($urandom_range(0, 9) < 6);
                ev_on    = ($urandom_range(0, 9) < 6);
                ev_note  = 7'(60 + $urandom_range(0, 7));
                ev_vel   = 8'($urandom);
                all_off  = ($urandom_range(0, 49) == 0);
            end
        end
        @(negedge clk_50m);
        ev_valid = 1'b0;
        all_off  = 1'b0;
        repeat (2) @(negedge clk_50m);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
